// File: rtl/radix8191_digit_serializer.sv
// radix8191_digit_serializer
// Splits an unsigned word into base-8191 digits, producing one digit per clock
// by repeated division. The digits are then streamed out over a valid/ready
// handshake, either least-significant first or most-significant first.
module radix8191_digit_serializer #(
  parameter int W         = 32,
  parameter bit LSD_FIRST = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [12:0]  out_digit_o,
  output logic [1:0]   out_idx_o,
  output logic         out_last_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_EMIT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cur_q, cur_d;
  logic [12:0] digitBuf_q [3];
  logic [12:0] digitBuf_d [3];
  logic [1:0]  n_q, n_d;
  logic [1:0]  emitCnt_q, emitCnt_d;

  logic [31:0] inWord;

  // Widen the input to the 32-bit internal datapath by padding with zeros.
  if (W < 32) begin : g_ext
    assign inWord = {{(32 - W){1'b0}}, in_data_i};
  end else begin : g_full
    assign inWord = in_data_i[31:0];
  end

  // Divide-by-8191 fold. Because 8192 is 1 modulo 8191, the high part of a
  // value can be added onto the low part without changing the residue. Three
  // folds bring the value into the range 0..8191. A result of 8191 is itself
  // a multiple of the divisor, so it becomes remainder 0 and adds one to the
  // quotient. The quotient is the sum of all the parts that were folded away.
  logic [18:0] foldHi;
  logic [19:0] foldA;
  logic [13:0] foldB;
  logic [12:0] foldC;
  logic        foldAllOnes;
  logic [12:0] divRem;
  logic [31:0] divQuo;

  assign foldHi      = cur_q[31:13];
  assign foldA       = {1'b0, foldHi} + {7'b0, cur_q[12:0]};
  assign foldB       = {7'b0, foldA[19:13]} + {1'b0, foldA[12:0]};
  assign foldC       = {12'b0, foldB[13]} + foldB[12:0];
  assign foldAllOnes = (foldC == 13'h1FFF);
  assign divRem      = foldAllOnes ? 13'd0 : foldC;
  assign divQuo      = {13'b0, foldHi} + {25'b0, foldA[19:13]}
                     + {31'b0, foldB[13]} + {31'b0, foldAllOnes};

  // Digit selection for the emit phase. The emit counter walks 0..n-1. The
  // digit index either follows the counter or runs backwards from n-1.
  logic [1:0]  lastCnt;
  logic [1:0]  selIdx;
  logic [12:0] selDigit;

  assign lastCnt = n_q - 2'd1;
  assign selIdx  = LSD_FIRST ? emitCnt_q : (lastCnt - emitCnt_q);

  // Read the buffered digit that the current emit slot refers to.
  always_comb begin
    selDigit = 13'd0;
    case (selIdx)
      2'd0:    selDigit = digitBuf_q[0];
      2'd1:    selDigit = digitBuf_q[1];
      2'd2:    selDigit = digitBuf_q[2];
      default: selDigit = 13'd0;
    endcase
  end

  // Next-state logic: accept a word, divide until the quotient is zero, then
  // hand out the digits one handshake at a time.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    n_d       = n_q;
    emitCnt_d = emitCnt_q;
    for (int k = 0; k < 3; k++) begin
      digitBuf_d[k] = digitBuf_q[k];
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          state_d = ST_DIV;
          cur_d   = inWord;
          n_d     = 2'd0;
        end
      end
      ST_DIV: begin
        for (int k = 0; k < 3; k++) begin
          if (n_q == 2'(k)) begin
            digitBuf_d[k] = divRem;
          end
        end
        cur_d = divQuo;
        n_d   = n_q + 2'd1;
        if (divQuo == 32'd0) begin
          state_d   = ST_EMIT;
          emitCnt_d = 2'd0;
        end
      end
      ST_EMIT: begin
        if (out_ready_i) begin
          if (emitCnt_q == lastCnt) begin
            state_d = ST_IDLE;
          end else begin
            emitCnt_d = emitCnt_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything, which discards
  // any word that is still being divided or emitted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cur_q     <= 32'd0;
      n_q       <= 2'd0;
      emitCnt_q <= 2'd0;
      for (int k = 0; k < 3; k++) begin
        digitBuf_q[k] <= 13'd0;
      end
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      n_q       <= n_d;
      emitCnt_q <= emitCnt_d;
      for (int k = 0; k < 3; k++) begin
        digitBuf_q[k] <= digitBuf_d[k];
      end
    end
  end

  // The outputs come straight from the registered state. While the block is
  // stalled in emit, the digit, index and last flag therefore hold their
  // values. They read as zero outside the emit phase.
  always_comb begin
    in_ready_o  = (state_q == ST_IDLE);
    busy_o      = (state_q != ST_IDLE);
    out_valid_o = 1'b0;
    out_digit_o = 13'd0;
    out_idx_o   = 2'd0;
    out_last_o  = 1'b0;
    if (state_q == ST_EMIT) begin
      out_valid_o = 1'b1;
      out_digit_o = selDigit;
      out_idx_o   = selIdx;
      out_last_o  = (emitCnt_q == lastCnt);
    end
  end

endmodule

// File: tb/tb_radix8191_digit_serializer.sv
// tb_radix8191_digit_serializer
// Drives two serializers with the same stimulus: one emits the least-significant
// digit first and the other the most-significant digit first. Both are checked
// every cycle against a digit model built from plain mod/div arithmetic.
module tb_radix8191_digit_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        inReadyL, outValidL, outLastL, busyL;
  logic [12:0] outDigitL;
  logic [1:0]  outIdxL;
  logic        inReadyM, outValidM, outLastM, busyM;
  logic [12:0] outDigitM;
  logic [1:0]  outIdxM;

  typedef struct {
    int digit;
    int idx;
    int last;
  } exp_t;

  exp_t qL[$];
  exp_t qM[$];
  int   logL[$];
  int   logM[$];
  int   divLeft;
  int   testsRun;
  int   testsFailed;
  bit   randReady;

  radix8191_digit_serializer #(.W(32), .LSD_FIRST(1'b1)) uL (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(inReadyL),
    .in_data_i(in_data), .out_valid_o(outValidL), .out_ready_i(out_ready),
    .out_digit_o(outDigitL), .out_idx_o(outIdxL), .out_last_o(outLastL),
    .busy_o(busyL)
  );

  radix8191_digit_serializer #(.W(32), .LSD_FIRST(1'b0)) uM (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(inReadyM),
    .in_data_i(in_data), .out_valid_o(outValidM), .out_ready_i(out_ready),
    .out_digit_o(outDigitM), .out_idx_o(outIdxM), .out_last_o(outLastM),
    .busy_o(busyM)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // The model splits the word into digits with real mod/div. It queues the
  // digits in both emit orders and waits one division cycle per digit.
  task automatic modelPush(input logic [31:0] x);
    longint unsigned v;
    int d[3];
    int n;
    exp_t e;
    v = 64'(x);
    n = 0;
    do begin
      d[n] = int'(v % 64'd8191);
      v    = v / 64'd8191;
      n++;
    end while (v != 0);
    for (int k = 0; k < n; k++) begin
      e.digit = d[k]; e.idx = k; e.last = (k == n - 1) ? 1 : 0;
      qL.push_back(e);
    end
    for (int k = n - 1; k >= 0; k--) begin
      e.digit = d[k]; e.idx = k; e.last = (k == 0) ? 1 : 0;
      qM.push_back(e);
    end
    divLeft = n;
  endtask

  // Every cycle, compare both DUTs against the model on the falling edge,
  // then advance the model to match the rising edge that follows.
  always @(negedge clk) begin : cmp
    bit expValid;
    bit expInReady;
    if (!rst_n) begin
      qL.delete();
      qM.delete();
      divLeft = 0;
    end
    expValid   = (divLeft == 0) && (qL.size() > 0);
    expInReady = (divLeft == 0) && (qL.size() == 0);
    checkOutput("in_ready L", int'(inReadyL), int'(expInReady));
    checkOutput("in_ready M", int'(inReadyM), int'(expInReady));
    checkOutput("busy L", int'(busyL), int'(!expInReady));
    checkOutput("busy M", int'(busyM), int'(!expInReady));
    checkOutput("out_valid L", int'(outValidL), int'(expValid));
    checkOutput("out_valid M", int'(outValidM), int'(expValid));
    if (expValid) begin
      checkOutput("digit L", int'(outDigitL), qL[0].digit);
      checkOutput("idx L", int'(outIdxL), qL[0].idx);
      checkOutput("last L", int'(outLastL), qL[0].last);
      checkOutput("digit M", int'(outDigitM), qM[0].digit);
      checkOutput("idx M", int'(outIdxM), qM[0].idx);
      checkOutput("last M", int'(outLastM), qM[0].last);
    end
    if (!rst_n) begin
      checkOutput("reset digit L", int'(outDigitL), 0);
      checkOutput("reset idx L", int'(outIdxL), 0);
      checkOutput("reset last L", int'(outLastL), 0);
      checkOutput("reset digit M", int'(outDigitM), 0);
      checkOutput("reset idx M", int'(outIdxM), 0);
      checkOutput("reset last M", int'(outLastM), 0);
    end else if (expValid && out_ready) begin
      logL.push_back(int'(outDigitL));
      logM.push_back(int'(outDigitM));
      void'(qL.pop_front());
      void'(qM.pop_front());
    end else if (divLeft > 0) begin
      divLeft--;
    end else if (expInReady && in_valid) begin
      modelPush(in_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present a word and hold it until the rising edge that accepts it.
  task automatic applyStimulus(input logic [31:0] x);
    bit accepted;
    logL.delete();
    logM.delete();
    in_valid = 1'b1;
    in_data  = x;
    accepted = 1'b0;
    for (int t = 0; t < 300 && !accepted; t++) begin
      accepted = inReadyL;
      tick();
    end
    in_valid = 1'b0;
    checkOutput("accept within budget", int'(accepted), 1);
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 300 && !idle; t++) begin
      tick();
      idle = inReadyL && (qL.size() == 0) && (divLeft == 0);
    end
    checkOutput("return to idle within budget", int'(idle), 1);
  endtask

  // Compare the digits that were transferred with hand-computed values given
  // in least-significant-first order.
  task automatic checkLog(input string name, input int cnt, input int e0, input int e1, input int e2);
    int e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    checkOutput({name, " count L"}, logL.size(), cnt);
    checkOutput({name, " count M"}, logM.size(), cnt);
    for (int k = 0; k < cnt; k++) begin
      if (k < logL.size()) checkOutput({name, " LSD digit"}, logL[k], e[k]);
      if (k < logM.size()) checkOutput({name, " MSD digit"}, logM[k], e[cnt - 1 - k]);
    end
  endtask

  task automatic runWord(input logic [31:0] x);
    applyStimulus(x);
    waitIdle();
  endtask

  initial begin
    bit seen;
    testsRun    = 0;
    testsFailed = 0;
    divLeft     = 0;
    randReady   = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 32'd0;
    out_ready   = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Zero gives a single digit, and out_valid appears after the first division edge.
    out_ready = 1'b0;
    applyStimulus(32'd0);
    checkOutput("x0 valid right after accept", int'(outValidL), 0);
    tick();
    checkOutput("x0 valid after one division", int'(outValidL), 1);
    checkOutput("x0 last", int'(outLastL), 1);
    out_ready = 1'b1;
    waitIdle();
    checkLog("x0", 1, 0, 0, 0);

    runWord(32'd8190);
    checkLog("x8190", 1, 8190, 0, 0);
    runWord(32'd8191);
    checkLog("x8191", 2, 0, 1, 0);
    runWord(32'hFFFFFFFF);
    checkLog("xFFFFFFFF", 3, 63, 128, 64);
    runWord(32'd67092481);
    checkLog("x8191sq", 3, 0, 0, 1);
    runWord(32'd67092480);
    checkLog("x8191sq-1", 2, 8190, 8190, 0);
    runWord(32'd123456789);
    checkLog("x123456789", 3, 2037, 6881, 1);

    // Stall the consumer for 5 cycles and pulse in_valid while busy.
    out_ready = 1'b0;
    applyStimulus(32'd8191);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      tick();
      seen = outValidL;
    end
    checkOutput("stall valid seen", int'(seen), 1);
    for (int t = 0; t < 5; t++) begin
      checkOutput("stall digit held", int'(outDigitL), 0);
      checkOutput("stall idx held", int'(outIdxL), 0);
      in_valid = (t == 1);
      in_data  = 32'd12345;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitIdle();
    checkLog("stalled x8191", 2, 0, 1, 0);

    // Reset in the middle of emitting all-ones, after one digit has transferred.
    out_ready = 1'b0;
    applyStimulus(32'hFFFFFFFF);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      tick();
      seen = outValidL;
    end
    checkOutput("emit reached", int'(seen), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset drops out_valid", int'(outValidL), 0);
    checkOutput("reset raises in_ready", int'(inReadyM), 1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    checkOutput("no digits after reset L", logL.size(), 1);
    checkOutput("partial first digit L", logL.size() > 0 ? logL[0] : -1, 63);
    checkOutput("partial first digit M", logM.size() > 0 ? logM[0] : -1, 64);
    runWord(32'd8191);
    checkLog("after reset x8191", 2, 0, 1, 0);

    // Random words with a random consumer; about 1 word in 8 is small.
    randReady = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 8 == 0) runWord(32'($urandom_range(0, 20000)));
      else            runWord($urandom);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
